// File: rtl/prod_accum_pkg.sv
// Shared definitions for the product accumulate-and-dump stage.
// Optional build macro: PROD_ACCUM_SATURATE_EN (used by prod_accum_adder).
package prod_accum_pkg;

    localparam int DATA_W = 8;
    localparam int ACC_W  = 2 * DATA_W;
    localparam int CNT_W  = 8;

    // Sample counter stops here rather than wrapping.
    localparam logic [CNT_W-1:0] COUNT_MAX = 8'd255;

    typedef enum logic [1:0] {
        ST_ACC   = 2'd0,
        ST_RD_LO = 2'd1,
        ST_RD_HI = 2'd2
    } state_e;

endpackage

// File: rtl/prod_accum_adder.sv
// Accumulator adder: acc_in + zero-extended data_in, with carry out.
// Build macro PROD_ACCUM_SATURATE_EN: clamp the sum at all-ones instead of
// wrapping; carry still reports that a clamp happened.
module prod_accum_adder
    import prod_accum_pkg::*;
#(
    parameter int DATA_W = prod_accum_pkg::DATA_W,
    parameter int ACC_W  = prod_accum_pkg::ACC_W
) (
    input  logic [ACC_W-1:0]  acc_in,
    input  logic [DATA_W-1:0] data_in,
    output logic [ACC_W-1:0]  sum,
    output logic              carry
);

    logic [ACC_W:0] raw;

    // Widen by one bit so the carry out of the top bit is visible.
    always_comb begin
        raw   = {1'b0, acc_in} + {{(ACC_W + 1 - DATA_W){1'b0}}, data_in};
        carry = raw[ACC_W];
`ifdef PROD_ACCUM_SATURATE_EN
        sum   = carry ? {ACC_W{1'b1}} : raw[ACC_W-1:0];
`else
        sum   = raw[ACC_W-1:0];
`endif
    end

endmodule

// File: rtl/prod_accum.sv
// Accumulate-and-dump stage behind the 8-bit operand multiplier.
// Sums product samples into a 16-bit accumulator and, on request, dumps it
// as two bytes (low then high), then clears.
// Build macro PROD_ACCUM_SATURATE_EN selects clamping instead of wrapping.
//
// state    | meaning
// ---------+----------------------------------------------
// ST_ACC   | accepting samples, watching clear / rd_req
// ST_RD_LO | presenting acc[7:0], waiting for out_ready
// ST_RD_HI | presenting acc[15:8], out_last=1; clears on handshake
module prod_accum
    import prod_accum_pkg::*;
#(
    parameter int DATA_W = prod_accum_pkg::DATA_W,
    parameter int ACC_W  = 2 * DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic              clear,
    input  logic              rd_req,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  count,
    output logic              ovf
);

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               ovf_q, ovf_d;

    logic [ACC_W-1:0]   add_base;
    logic [ACC_W-1:0]   add_sum;
    logic               add_carry;
    logic               accept;

    // A clear in the same cycle as a sample means the sample starts from zero.
    always_comb begin
        add_base = clear ? '0 : acc_q;
    end

    prod_accum_adder #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_adder (
        .acc_in  (add_base),
        .data_in (in_data),
        .sum     (add_sum),
        .carry   (add_carry)
    );

    // Outputs decode only from registered state and acc; reset forces them low.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        out_last  = 1'b0;
        if (rst_n) begin
            case (state_q)
                ST_ACC: begin
                    in_ready = ena;
                end
                ST_RD_LO: begin
                    out_valid = ena;
                    out_data  = acc_q[DATA_W-1:0];
                end
                ST_RD_HI: begin
                    out_valid = ena;
                    out_data  = acc_q[ACC_W-1:DATA_W];
                    out_last  = 1'b1;
                end
                default: begin
                    in_ready = 1'b0;
                end
            endcase
        end
        count = count_q;
        ovf   = ovf_q;
    end

    // Next-state: accumulate / command handling in ST_ACC, byte readout otherwise.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        accept  = 1'b0;
        if (ena) begin
            case (state_q)
                ST_ACC: begin
                    accept = in_valid;
                    if (clear) begin
                        acc_d   = '0;
                        count_d = '0;
                        ovf_d   = 1'b0;
                    end
                    if (accept) begin
                        acc_d   = add_sum;
                        count_d = clear ? CNT_W'(1)
                                : (count_q == COUNT_MAX) ? COUNT_MAX
                                : count_q + CNT_W'(1);
                        ovf_d   = (clear ? 1'b0 : ovf_q) | add_carry;
                    end
                    if (rd_req && !clear) begin
                        state_d = ST_RD_LO;
                    end
                end
                ST_RD_LO: begin
                    if (out_ready) begin
                        state_d = ST_RD_HI;
                    end
                end
                ST_RD_HI: begin
                    if (out_ready) begin
                        state_d = ST_ACC;
                        acc_d   = '0;
                        count_d = '0;
                        ovf_d   = 1'b0;
                    end
                end
                default: begin
                    state_d = ST_ACC;
                end
            endcase
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_ACC;
            acc_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_prod_accum.sv
// Directed bench for prod_accum; readout beats are checked by a scoreboard.
module tb_prod_accum;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       clear;
    logic       rd_req;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_last;
    logic       out_ready;
    logic [7:0] count;
    logic       ovf;

    int n_cmp = 0;
    int n_err = 0;
    logic [8:0] exp_q[$];

    always #5 clk = ~clk;

    prod_accum dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .clear     (clear),
        .rd_req    (rd_req),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ready (out_ready),
        .count     (count),
        .ovf       (ovf)
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    // Monitor: every accepted readout beat is matched against the queue head.
    always @(negedge clk) begin
        logic [8:0] e;
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", {7'd0, out_last, out_data}, 16'hFFFF);
            end else begin
                e = exp_q.pop_front();
                check("beat_data", {8'd0, out_data}, {8'd0, e[7:0]});
                check("beat_last", {15'd0, out_last}, {15'd0, e[8]});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic send_n(input int n, input logic [7:0] d);
        for (int i = 0; i < n; i++) send(d);
    endtask

    // Full dump with out_ready held high; expected beats go to the scoreboard.
    task automatic dump(input logic [15:0] exp);
        exp_q.push_back({1'b0, exp[7:0]});
        exp_q.push_back({1'b1, exp[15:8]});
        rd_req    = 1'b1;
        out_ready = 1'b1;
        tick();
        rd_req = 1'b0;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        check("dump_drained", 16'(exp_q.size()), 16'd0);
        out_ready = 1'b0;
        @(negedge clk);
        check("post_dump_count", {8'd0, count}, 16'd0);
        check("post_dump_ovf", {15'd0, ovf}, 16'd0);
        tick();
    endtask

    task automatic clear_with(input logic [7:0] d);
        clear    = 1'b1;
        in_valid = 1'b1;
        in_data  = d;
        tick();
        clear    = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; ena = 1'b1; in_valid = 1'b0; in_data = 8'h00;
        clear = 1'b0; rd_req = 1'b0; out_ready = 1'b0;

        // Reset behaviour
        repeat (2) tick();
        @(negedge clk);
        check("rst_in_ready", {15'd0, in_ready}, 16'd0);
        check("rst_out_valid", {15'd0, out_valid}, 16'd0);
        check("rst_out_data", {8'd0, out_data}, 16'd0);
        check("rst_out_last", {15'd0, out_last}, 16'd0);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_count", {8'd0, count}, 16'd0);
        check("rel_ovf", {15'd0, ovf}, 16'd0);
        check("rel_in_ready", {15'd0, in_ready}, 16'd1);
        tick();

        // Basic sum and dump
        send(8'h10); send(8'h20); send(8'h30);
        @(negedge clk);
        check("basic_count", {8'd0, count}, 16'd3);
        tick();
        dump(16'h0060);

        // 257 x 0xFF = 0xFFFF, count saturates, no carry
        send_n(257, 8'hFF);
        @(negedge clk);
        check("sat_count", {8'd0, count}, 16'd255);
        check("no_ovf", {15'd0, ovf}, 16'd0);
        tick();
        dump(16'hFFFF);

        // Preload 0xFFF0 then add 0x20
        send_n(256, 8'hFF);
        send(8'hF0);
        send(8'h20);
        @(negedge clk);
        check("wrap_ovf", {15'd0, ovf}, 16'd1);
        tick();
`ifdef PROD_ACCUM_SATURATE_EN
        dump(16'hFFFF);
`else
        dump(16'h0010);
`endif

        // clear with concurrent sample drops sticky ovf
        send_n(257, 8'hFF);
        send(8'h02);
        @(negedge clk);
        check("pre_clear_ovf", {15'd0, ovf}, 16'd1);
        tick();
        clear_with(8'h05);
        @(negedge clk);
        check("clr_ovf_ovf", {15'd0, ovf}, 16'd0);
        check("clr_ovf_count", {8'd0, count}, 16'd1);
        tick();
        dump(16'h0005);

        // acc = 0x1234, then clear + sample 0x05
        send_n(18, 8'hFF);
        send(8'h46);
        clear_with(8'h05);
        @(negedge clk);
        check("clr_count", {8'd0, count}, 16'd1);
        check("clr_ovf", {15'd0, ovf}, 16'd0);
        tick();
        dump(16'h0005);

        // clear + rd_req together: no dump
        send(8'h33);
        clear = 1'b1; rd_req = 1'b1; out_ready = 1'b1;
        tick();
        clear = 1'b0; rd_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("clr_rd_no_valid", {15'd0, out_valid}, 16'd0);
            tick();
        end
        out_ready = 1'b0;
        @(negedge clk);
        check("clr_rd_count", {8'd0, count}, 16'd0);
        tick();

        // Backpressure and ena stall during dump, sample offered throughout
        send(8'hAB); send(8'hCD);
        exp_q.push_back({1'b0, 8'h78});
        exp_q.push_back({1'b1, 8'h01});
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0; in_valid = 1'b1; in_data = 8'h77;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_lo_valid", {15'd0, out_valid}, 16'd1);
            check("stall_lo_data", {8'd0, out_data}, 16'h0078);
            check("stall_lo_last", {15'd0, out_last}, 16'd0);
            check("stall_lo_in_ready", {15'd0, in_ready}, 16'd0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_hi_data", {8'd0, out_data}, 16'h0001);
            check("stall_hi_last", {15'd0, out_last}, 16'd1);
            check("stall_hi_in_ready", {15'd0, in_ready}, 16'd0);
            tick();
        end
        ena = 1'b0;
        @(negedge clk);
        check("ena_low_valid", {15'd0, out_valid}, 16'd0);
        tick(); tick();
        ena = 1'b1;
        @(negedge clk);
        check("ena_back_valid", {15'd0, out_valid}, 16'd1);
        check("ena_back_data", {8'd0, out_data}, 16'h0001);
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        check("stall_drained", 16'(exp_q.size()), 16'd0);
        check("stall_count", {8'd0, count}, 16'd0);
        tick();

        // Reset during RD_HI abandons the dump
        send(8'h11); send(8'h22);
        exp_q.push_back({1'b0, 8'h33});
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0; out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        @(negedge clk);
        check("rd_hi_valid", {15'd0, out_valid}, 16'd1);
        check("rd_hi_count", {8'd0, count}, 16'd2);
        rst_n = 1'b0;
        #1;
        check("rst_mid_valid", {15'd0, out_valid}, 16'd0);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_mid_count", {8'd0, count}, 16'd0);
        check("rst_mid_out_valid", {15'd0, out_valid}, 16'd0);
        check("rst_mid_in_ready", {15'd0, in_ready}, 16'd1);
        check("rst_mid_drained", 16'(exp_q.size()), 16'd0);
        tick();

        // Block works normally after the abandoned dump
        send(8'h01); send(8'h02);
        dump(16'h0003);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
